writeback_unit: RTL
===================

# writeback_unit

Writeback stage that drives the core's single register-file write port from two result sources: the single-cycle ALU and the long-latency load/store unit (LSU). It arbitrates between them, buffers LSU results in a small FIFO, and registers the winning result onto write_reg/write_data/reg_write. A per-register scoreboard tracks destinations with outstanding long-latency results so that the issue logic can stall on operands that are not yet written.

## Interface
- FIFO_DEPTH, 2, LSU result buffer entries; must be a power of 2 and at least 2.
- STARVE_LIMIT, 4, consecutive ALU wins allowed while an LSU result waits; must be at least 1.

- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU result valid.
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- alu_ready  out  1  ALU result accepted this cycle when alu_valid is also high.
- lsu_valid  in  1  LSU result valid.
- lsu_rd  in  5  LSU destination register.
- lsu_data  in  32  LSU result.
- lsu_ready  out  1  FIFO not full.
- issue_valid  in  1  an instruction issues this cycle.
- issue_long  in  1  the issuing instruction completes through the LSU.
- issue_rd  in  5  destination of the issuing instruction.
- rs1, rs2  in  5 each  operand registers queried by issue.
- rs1_busy, rs2_busy  out  1 each  the operand has a pending LSU writeback. Combinational from the scoreboard.
- write_reg  out  5  register-file write address.
- write_data  out  32  register-file write data.
- reg_write  out  1  register-file write enable.

## Operation
- Transfers:
  - ALU transfer = alu_valid & alu_ready.
  - LSU transfer = lsu_valid & lsu_ready; the result is pushed into the FIFO.
- Arbitration each cycle, with F = FIFO non-empty:
  - If alu_valid & alu_ready, the ALU wins.
  - Otherwise, if F, the FIFO head wins and is popped.
- Starvation counter:
  - Increments on each cycle with an ALU transfer while F is true.
  - Clears when F is false or the FIFO head is popped.
  - alu_ready = !(F & counter == STARVE_LIMIT). That cycle the FIFO head is forced to win.
- The winner is loaded into the output registers: write_reg, write_data, reg_write = (rd != 0), and an internal src_lsu flag.
  - With no winner, reg_write loads 0.
  - write_reg and write_data hold their last value when reg_write is 0.
- Results for rd = 0 are consumed normally but never assert reg_write.
- Scoreboard (32 bits; bit 0 is constant 0):
  - Set: issue_valid & issue_long & issue_rd != 0 sets bit issue_rd.
  - Clear: reg_write & src_lsu clears bit write_reg at the edge ending the reg_write cycle, i.e. the same edge the register file commits the data.
  - Simultaneous set and clear of the same bit: set wins.
- lsu_ready = FIFO count < FIFO_DEPTH. A push and a pop in the same cycle with the FIFO full is not allowed, because lsu_ready is low.
- FIFO pointers are log2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH. The count is one bit wider.
- Order: LSU results are written in arrival order. No ordering is enforced between the ALU and LSU paths; issue guarantees no WAW hazard through the scoreboard.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert by the system) sets:
  - reg_write, write_reg, write_data: 0.
  - FIFO empty, so lsu_ready = 1.
  - Scoreboard clear, so rs1_busy = rs2_busy = 0.
  - Counter = 0, so alu_ready = 1.
- Reset mid-operation discards FIFO contents and pending scoreboard bits. No write occurs after reset asserts.
- ALU latency: accepted at edge t, reg_write is high in cycle t..t+1 and committed at edge t+1.
- LSU latency: pushed at edge t, earliest pop in cycle t..t+1, reg_write high in the following cycle. That is 2 cycles minimum.
- LSU throughput: one result per cycle when the ALU is idle.
- rs_busy drops in the cycle after the register-file commit edge. The register file then already holds the new data.

## Test plan
- Reset state:
  - Stimulus: hold reset low with random inputs.
  - Required: reg_write = 0, lsu_ready = 1, alu_ready = 1, busy = 0.
  - Release reset, then send alu_valid, rd = 5, data = 0x1234 → next cycle reg_write = 1, write_reg = 5, write_data = 0x1234.
- Scoreboard set and clear:
  - Stimulus: issue_long with rd = 7, then rs1 = 7. Required: rs1_busy = 1.
  - Send lsu rd = 7, data = 0xDEADBEEF with the ALU idle. Required: reg_write 2 cycles later, then rs1_busy = 0 the cycle after.
- Starvation:
  - Stimulus: continuous alu_valid and one LSU result.
  - Required: 4 ALU writes, then alu_ready = 0 for one cycle, the LSU write, then ALU writes resume.
- FIFO full:
  - Stimulus: continuous ALU plus 3 back-to-back LSU results with STARVE_LIMIT large.
  - Required: lsu_ready = 0 after 2 pushes; the LSU data is written in order once it drains.
- x0 handling:
  - Stimulus: ALU and LSU results with rd = 0, plus issue_long with rd = 0.
  - Required: reg_write stays 0, both results are consumed, busy for rs = 0 stays 0.
- Same-edge set and clear:
  - Stimulus: issue_long rd = 9 on the same edge that an LSU write to rd = 9 commits.
  - Required: bit 9 stays set.

Source files
------------

// File: rtl/writeback_unit.sv
// writeback_unit: arbitrates ALU and buffered LSU results onto the single
// register-file write port and tracks destinations with pending LSU writes.
module writeback_unit #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        lsu_valid,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  output logic        lsu_ready,
  input  logic        issue_valid,
  input  logic        issue_long,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic        reg_write
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]    rd_mem_q  [FIFO_DEPTH];
  logic [31:0]   dat_mem_q [FIFO_DEPTH];
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   sb_q, sb_d;

  logic          reg_write_q;
  logic          src_lsu_q;
  logic [4:0]    write_reg_q;
  logic [31:0]   write_data_q;

  logic          f;
  logic          alu_xfer;
  logic          push;
  logic          pop;
  logic          win_wr;
  logic [4:0]    win_rd;
  logic [31:0]   win_data;

  assign f         = cnt_q != '0;
  assign alu_ready = !(f && starve_q == SW'(STARVE_LIMIT));
  assign lsu_ready = cnt_q < CW'(FIFO_DEPTH);
  assign alu_xfer  = alu_valid && alu_ready;
  assign push      = lsu_valid && lsu_ready;
  assign pop       = f && !alu_xfer;

  assign win_rd   = alu_xfer ? alu_rd   : rd_mem_q[rptr_q];
  assign win_data = alu_xfer ? alu_data : dat_mem_q[rptr_q];
  assign win_wr   = (alu_xfer || pop) && win_rd != 5'd0;

  always_comb begin
    rptr_d   = pop  ? rptr_q + PW'(1) : rptr_q;
    wptr_d   = push ? wptr_q + PW'(1) : wptr_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    starve_d = starve_q;
    if (!f || pop)
      starve_d = '0;
    else if (alu_xfer)
      starve_d = starve_q + SW'(1);
  end

  // A new long-latency issue to a register outranks the commit clearing it.
  always_comb begin
    sb_d = sb_q;
    if (reg_write_q && src_lsu_q)
      sb_d[write_reg_q] = 1'b0;
    if (issue_valid && issue_long && issue_rd != 5'd0)
      sb_d[issue_rd] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_q[wptr_q]  <= lsu_rd;
      dat_mem_q[wptr_q] <= lsu_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rptr_q       <= '0;
      wptr_q       <= '0;
      cnt_q        <= '0;
      starve_q     <= '0;
      sb_q         <= '0;
      reg_write_q  <= 1'b0;
      src_lsu_q    <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      rptr_q      <= rptr_d;
      wptr_q      <= wptr_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      sb_q        <= sb_d;
      reg_write_q <= win_wr;
      if (win_wr) begin
        write_reg_q  <= win_rd;
        write_data_q <= win_data;
        src_lsu_q    <= !alu_xfer;
      end
    end
  end

  assign rs1_busy   = sb_q[rs1];
  assign rs2_busy   = sb_q[rs2];
  assign reg_write  = reg_write_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;

endmodule
